// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: picks at most one fetch-PC redirect per cycle from the
// exception, branch, jr and predictor sources. While the I-cache is busy the
// redirect is parked, and F2 is told to drop the wrong-path response that is
// still in flight.
module fetch_redirect_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              excp_valid,
    input  logic [ADDR_W-1:0] excp_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_pc,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_pc,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_pc,
    input  logic              i_wait,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [1:0]        redirect_src,
    output logic              pend_valid,
    output logic              discard_resp,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [1:0] SRC_EXCP   = 2'd3;
    localparam logic [1:0] SRC_BRANCH = 2'd2;
    localparam logic [1:0] SRC_JR     = 2'd1;
    localparam logic [1:0] SRC_PRED   = 2'd0;

    logic              pend_valid_r;
    logic [1:0]        pend_src_r;
    logic [ADDR_W-1:0] pend_pc_r;
    logic              discard_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              in_valid_s;
    logic [1:0]        in_pri_s;
    logic [ADDR_W-1:0] in_pc_s;
    logic              take_in_s;
    logic              cand_valid_s;
    logic [1:0]        cand_src_s;
    logic [ADDR_W-1:0] cand_pc_s;
    logic              issue_s;

    // Fixed-priority pick among the incoming requests: excp > branch > jr > pred.
    always_comb begin
        in_valid_s = excp_valid | branch_valid | jr_valid | pred_valid;
        in_pri_s   = SRC_PRED;
        in_pc_s    = {ADDR_W{1'b0}};
        if (excp_valid) begin
            in_pri_s = SRC_EXCP;
            in_pc_s  = excp_pc;
        end else if (branch_valid) begin
            in_pri_s = SRC_BRANCH;
            in_pc_s  = branch_pc;
        end else if (jr_valid) begin
            in_pri_s = SRC_JR;
            in_pc_s  = jr_pc;
        end else if (pred_valid) begin
            in_pri_s = SRC_PRED;
            in_pc_s  = pred_pc;
        end else begin
            in_pri_s = SRC_PRED;
            in_pc_s  = {ADDR_W{1'b0}};
        end
    end

    // Merge with the parked entry: a newer request of equal or higher priority
    // replaces it; a lower-priority one is from an already-flushed path and is dropped.
    always_comb begin
        take_in_s    = in_valid_s & (~pend_valid_r | (in_pri_s >= pend_src_r));
        cand_valid_s = take_in_s | pend_valid_r;
        cand_src_s   = 2'd0;
        cand_pc_s    = {ADDR_W{1'b0}};
        if (take_in_s) begin
            cand_src_s = in_pri_s;
            cand_pc_s  = in_pc_s;
        end else if (pend_valid_r) begin
            cand_src_s = pend_src_r;
            cand_pc_s  = pend_pc_r;
        end else begin
            cand_src_s = 2'd0;
            cand_pc_s  = {ADDR_W{1'b0}};
        end
    end

    // Issue the candidate straight through when fetch can take a new PC; outputs
    // are zero whenever nothing is issued.
    always_comb begin
        issue_s        = cand_valid_s & ~i_wait;
        redirect_valid = issue_s;
        redirect_pc    = {ADDR_W{1'b0}};
        redirect_src   = 2'd0;
        if (issue_s) begin
            redirect_pc  = cand_pc_s;
            redirect_src = cand_src_s;
        end else begin
            redirect_pc  = {ADDR_W{1'b0}};
            redirect_src = 2'd0;
        end
        discard_resp = discard_r & ~i_wait;
        pend_valid   = pend_valid_r;
        redirect_cnt = cnt_r;
    end

    // Parked-redirect state, discard flag and issued-redirect counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_src_r   <= 2'd0;
            pend_pc_r    <= {ADDR_W{1'b0}};
            discard_r    <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else if (!i_wait) begin
            // The outstanding response (if any) returns this cycle, so the
            // discard flag is consumed and any candidate has just been issued.
            pend_valid_r <= 1'b0;
            discard_r    <= 1'b0;
            if (issue_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else if (cand_valid_s) begin
            pend_valid_r <= 1'b1;
            pend_src_r   <= cand_src_s;
            pend_pc_r    <= cand_pc_s;
            // A fresh redirect means the response now in flight is wrong-path.
            if (take_in_s) begin
                discard_r <= 1'b1;
            end else begin
                discard_r <= discard_r;
            end
        end else begin
            pend_valid_r <= pend_valid_r;
            discard_r    <= discard_r;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios followed by random traffic,
// all checked against a small behavioural model of the redirect rules.
module tb_fetch_redirect_ctrl;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          excp_valid = 1'b0, branch_valid = 1'b0, jr_valid = 1'b0, pred_valid = 1'b0;
    logic [AW-1:0] excp_pc = '0, branch_pc = '0, jr_pc = '0, pred_pc = '0;
    logic          i_wait = 1'b0;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [1:0]    redirect_src;
    logic          pend_valid;
    logic          discard_resp;
    logic [CW-1:0] redirect_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: the parked redirect, the "response in flight is
    // stale" flag and the number of issued redirects.
    bit          m_pend = 1'b0;
    int          m_pri  = 0;
    logic [31:0] m_pc   = 32'h0;
    bit          m_disc = 1'b0;
    int          m_cnt  = 0;

    fetch_redirect_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .excp_valid(excp_valid), .excp_pc(excp_pc),
        .branch_valid(branch_valid), .branch_pc(branch_pc),
        .jr_valid(jr_valid), .jr_pc(jr_pc),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .i_wait(i_wait),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_src(redirect_src), .pend_valid(pend_valid),
        .discard_resp(discard_resp), .redirect_cnt(redirect_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the same-cycle outputs against the
    // model before the edge, advance the model, then check the registered state.
    // v = {excp, branch, jr, pred}.
    task automatic step(input string tag, input bit rst, input bit [3:0] v,
                        input logic [31:0] p3, input logic [31:0] p2,
                        input logic [31:0] p1, input logic [31:0] p0, input bit w);
        logic [31:0] pcs [4];
        int          win;
        bit          take, cand, e_valid;
        int          c_pri;
        logic [31:0] c_pc;
        reset = rst; i_wait = w;
        excp_valid = v[3]; branch_valid = v[2]; jr_valid = v[1]; pred_valid = v[0];
        excp_pc = p3; branch_pc = p2; jr_pc = p1; pred_pc = p0;
        pcs[3] = p3; pcs[2] = p2; pcs[1] = p1; pcs[0] = p0;
        win = -1;
        for (int s = 3; s >= 0; s--) if (v[s] && win < 0) win = s;
        take  = (win >= 0) && (!m_pend || win >= m_pri);
        cand  = take || m_pend;
        c_pri = take ? win : m_pri;
        c_pc  = take ? pcs[win] : m_pc;
        e_valid = cand && !w;
        @(negedge clk);
        if (!rst) begin
            chk({tag, ".valid"},   {31'h0, redirect_valid}, {31'h0, e_valid});
            chk({tag, ".pc"},      redirect_pc, e_valid ? c_pc : 32'h0);
            chk({tag, ".src"},     {30'h0, redirect_src}, e_valid ? c_pri : 0);
            chk({tag, ".discard"}, {31'h0, discard_resp}, {31'h0, m_disc && !w});
        end
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0; m_pri = 0; m_pc = 32'h0; m_disc = 1'b0; m_cnt = 0;
        end else if (!w) begin
            m_pend = 1'b0; m_disc = 1'b0;
            if (e_valid) m_cnt = (m_cnt + 1) % (1 << CW);
        end else if (cand) begin
            m_pend = 1'b1; m_pri = c_pri; m_pc = c_pc;
            if (take) m_disc = 1'b1;
        end
        #1;
        chk({tag, ".pend"}, {31'h0, pend_valid}, {31'h0, m_pend});
        chk({tag, ".cnt"},  {28'h0, redirect_cnt}, m_cnt);
    endtask

    initial begin
        // Reset and idle state.
        step("rst", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
        step("idle", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);

        // Single branch redirect with the cache idle.
        step("t1", 1'b0, 4'b0100, 0, 32'h8000_0100, 0, 0, 1'b0);
        chk("t1.cnt_lit", {28'h0, redirect_cnt}, 32'd1);
        step("t1b", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);

        // jr parked across a busy cache, issued with discard when i_wait falls.
        step("rst2", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
        step("t2c1", 1'b0, 4'b0010, 0, 0, 32'hBFC0_0040, 0, 1'b1);
        step("t2c2", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b1);
        step("t2c3", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b1);
        step("t2c4", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
        step("t2c5", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
        chk("t2.cnt_lit", {28'h0, redirect_cnt}, 32'd1);

        // Higher priority replaces a parked pred; a later pred is dropped.
        step("rst3", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
        step("t3a", 1'b0, 4'b0001, 0, 0, 0, 32'h100, 1'b1);
        step("t3b", 1'b0, 4'b0100, 0, 32'h200, 0, 0, 1'b1);
        step("t3c", 1'b0, 4'b0001, 0, 0, 0, 32'h300, 1'b1);
        step("t3d", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
        chk("t3.cnt_lit", {28'h0, redirect_cnt}, 32'd1);

        // All four sources at once: exception wins.
        step("rst4", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
        step("t4", 1'b0, 4'b1111, 32'hBFC0_0380, 32'h400, 32'h500, 32'h600, 1'b0);
        step("t4b", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);

        // Equal priority: a newer jr overwrites the parked jr.
        step("teq1", 1'b0, 4'b0010, 0, 0, 32'h1110, 0, 1'b1);
        step("teq2", 1'b0, 4'b0010, 0, 0, 32'h2220, 0, 1'b1);
        step("teq3", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);

        // Reset while a jr is parked loses it.
        step("t5a", 1'b0, 4'b0010, 0, 0, 32'h700, 0, 1'b1);
        step("t5rst", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b1);
        step("t5b", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
        step("t5c", 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);

        // Counter wrap: 16 back-to-back redirects.
        for (int i = 0; i < 16; i++) begin
            step("t6", 1'b0, 4'b0001 << (i % 4), $urandom, $urandom, $urandom, $urandom, 1'b0);
        end
        chk("t6.wrap", {28'h0, redirect_cnt}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit [3:0] rv;
            for (int s = 0; s < 4; s++) rv[s] = ($urandom_range(0, 3) == 0);
            step("rnd", ($urandom_range(0, 63) == 0), rv,
                 $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
